// File: rtl/hazard_control_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_control_unit_if
//
// Bundle of every signal exchanged between the pipeline datapath and the
// hazard control unit.
//
//   master : pipeline side. Drives Decode/Execute/Memory/Writeback register
//            info and receives the stall/flush/forward controls and statistics.
//   slave  : hazard control unit side (mirror of master).
//
// Parameter:
//   CNT_W  width of the saturating statistics counters (must match the unit).
// -----------------------------------------------------------------------------
interface hazard_control_unit_if #(
  parameter int CNT_W = 16
);

  // Decode stage
  logic [4:0]       reg_read_addr1_d;
  logic [4:0]       reg_read_addr2_d;
  logic [1:0]       reg_read_en_d;     // [0]=rs1 used, [1]=rs2 used

  // Execute stage
  logic [4:0]       reg_read_addr1_e;
  logic [4:0]       reg_read_addr2_e;
  logic [4:0]       reg_write_addr_e;
  logic             reg_write_en_e;
  logic             dmem_read_en_e;
  logic             mul_en_e;
  logic             pc_redirect_e;

  // Memory / Writeback destination info
  logic [4:0]       reg_write_addr_m;
  logic             reg_write_en_m;
  logic [4:0]       reg_write_addr_w;
  logic             reg_write_en_w;

  // Pipeline controls
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             flush_d;
  logic             flush_e;
  logic             flush_m;
  logic [1:0]       forward_a_e;       // 00 regfile, 01 W result, 10 M result
  logic [1:0]       forward_b_e;
  logic             mul_busy;

  // Statistics
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output reg_read_addr1_d, reg_read_addr2_d, reg_read_en_d,
    output reg_read_addr1_e, reg_read_addr2_e, reg_write_addr_e,
    output reg_write_en_e, dmem_read_en_e, mul_en_e, pc_redirect_e,
    output reg_write_addr_m, reg_write_en_m,
    output reg_write_addr_w, reg_write_en_w,
    input  stall_f, stall_d, stall_e,
    input  flush_d, flush_e, flush_m,
    input  forward_a_e, forward_b_e, mul_busy,
    input  stall_cycles, flush_events
  );

  modport slave (
    input  reg_read_addr1_d, reg_read_addr2_d, reg_read_en_d,
    input  reg_read_addr1_e, reg_read_addr2_e, reg_write_addr_e,
    input  reg_write_en_e, dmem_read_en_e, mul_en_e, pc_redirect_e,
    input  reg_write_addr_m, reg_write_en_m,
    input  reg_write_addr_w, reg_write_en_w,
    output stall_f, stall_d, stall_e,
    output flush_d, flush_e, flush_m,
    output forward_a_e, forward_b_e, mul_busy,
    output stall_cycles, flush_events
  );

endinterface : hazard_control_unit_if

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//
// Pipeline controller for the 5-stage RV32 core. Sequences Decode and the
// Execute-stage multiplier:
//   - branch/jump redirects resolved in Execute flush the F/D and D/E registers
//   - a multi-cycle multiply freezes F, D and E until its result is ready,
//     bubbling E/M meanwhile
//   - a load followed by a dependent instruction in Decode stalls one cycle
//   - Execute operand forwarding selects (M result over W result)
//   - saturating counters of stalled cycles and redirect flushes
//
// Ports:
//   clk    core clock
//   rst_n  synchronous active-low reset; while low all stages are flushed
//   bus    hazard_control_unit_if.slave (stage info in, controls/stats out)
//
// Parameters:
//   MUL_LAT  multiplier latency in cycles (>=1); result valid in the
//            MUL_LAT-th cycle the multiply sits in Execute
//   CNT_W    statistics counter width
// -----------------------------------------------------------------------------
module hazard_control_unit #(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_control_unit_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int MUL_CNT_W = $clog2(MUL_LAT) + 1;

  // A single-cycle multiplier behaves like any other ALU op.
  localparam bit MUL_STALLS = (MUL_LAT > 1);

  // The issue cycle counts as the first of MUL_LAT cycles and the release
  // cycle (mul_cnt==0) as the last, hence the reload of MUL_LAT-2.
  localparam logic [MUL_CNT_W-1:0] MUL_RELOAD =
    (MUL_LAT > 1) ? MUL_CNT_W'(MUL_LAT - 2) : '0;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MUL_WAIT = 1'b1;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic flush_d;
    logic flush_e;
    logic flush_m;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE     = '{default: 1'b0};
  localparam ctrl_t CTRL_RESET    = '{flush_d: 1'b1, flush_e: 1'b1,
                                      flush_m: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_REDIRECT = '{flush_d: 1'b1, flush_e: 1'b1,
                                      default: 1'b0};
  localparam ctrl_t CTRL_MUL      = '{stall_f: 1'b1, stall_d: 1'b1,
                                      stall_e: 1'b1, flush_m: 1'b1,
                                      default: 1'b0};
  localparam ctrl_t CTRL_LOAD_USE = '{stall_f: 1'b1, stall_d: 1'b1,
                                      flush_e: 1'b1, default: 1'b0};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]           state_q,   state_d;
  logic [MUL_CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0]     stall_cycles_q;
  logic [CNT_W-1:0]     flush_events_q;

  ctrl_t                ctrl;
  logic                 load_use;
  logic                 redirect_run;

  // ---------------------------------------------------------------------------
  // Load-use detection: the Decode instruction needs a register that the load
  // in Execute has not fetched yet. x0 is never a real dependency.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_use = bus.dmem_read_en_e && bus.reg_write_en_e &&
               (bus.reg_write_addr_e != 5'd0) &&
               ((bus.reg_read_en_d[0] &&
                 (bus.reg_read_addr1_d == bus.reg_write_addr_e)) ||
                (bus.reg_read_en_d[1] &&
                 (bus.reg_read_addr2_d == bus.reg_write_addr_e)));
  end

  // ---------------------------------------------------------------------------
  // Control decode and next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    ctrl         = CTRL_NONE;
    state_d      = state_q;
    mul_cnt_d    = mul_cnt_q;
    redirect_run = 1'b0;

    if (!rst_n) begin
      // Next state is irrelevant here: the register block forces RUN.
      ctrl = CTRL_RESET;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.pc_redirect_e) begin
            // Wrong-path instructions in D and E are discarded; this wins over
            // any stall because the stalled instructions are dead anyway.
            ctrl         = CTRL_REDIRECT;
            redirect_run = 1'b1;
          end else if (bus.mul_en_e && MUL_STALLS) begin
            ctrl      = CTRL_MUL;
            state_d   = ST_MUL_WAIT;
            mul_cnt_d = MUL_RELOAD;
          end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
          end
        end

        ST_MUL_WAIT: begin
          // E is occupied by the multiply, so redirects and load-use hazards
          // cannot originate from E here and are ignored.
          if (mul_cnt_q == '0) begin
            // Result is valid this cycle: let the multiply move on to M.
            state_d = ST_RUN;
          end else begin
            ctrl      = CTRL_MUL;
            mul_cnt_d = mul_cnt_q - MUL_CNT_W'(1);
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding: the youngest producer (M) wins over W; x0 is never forwarded.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       wen_m,
    input logic [4:0] rd_m,
    input logic       wen_w,
    input logic [4:0] rd_w
  );
    if (wen_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return 2'b10;
    end else if (wen_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values of
    // the previous cycle regardless of statement order.
    if (!rst_n) begin
      state_q        <= ST_RUN;
      mul_cnt_q      <= '0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;

      if (ctrl.stall_d && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      end

      if (redirect_run && (flush_events_q != '1)) begin
        flush_events_q <= flush_events_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.stall_f = ctrl.stall_f;
  assign bus.stall_d = ctrl.stall_d;
  assign bus.stall_e = ctrl.stall_e;
  assign bus.flush_d = ctrl.flush_d;
  assign bus.flush_e = ctrl.flush_e;
  assign bus.flush_m = ctrl.flush_m;

  assign bus.forward_a_e = rst_n ? fwd_sel(bus.reg_read_addr1_e,
                                           bus.reg_write_en_m, bus.reg_write_addr_m,
                                           bus.reg_write_en_w, bus.reg_write_addr_w)
                                 : 2'b00;
  assign bus.forward_b_e = rst_n ? fwd_sel(bus.reg_read_addr2_e,
                                           bus.reg_write_en_m, bus.reg_write_addr_m,
                                           bus.reg_write_en_w, bus.reg_write_addr_w)
                                 : 2'b00;

  assign bus.mul_busy     = rst_n && (state_q == ST_MUL_WAIT);
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_events = flush_events_q;

  // ---------------------------------------------------------------------------
  // Protocol checks and invariants
  // ---------------------------------------------------------------------------
  // E holds the multiply, so nothing in E can resolve a redirect.
  a_no_redirect_in_mul_wait: assert property (
    @(posedge clk) disable iff (!rst_n)
      (state_q == ST_MUL_WAIT) |-> !bus.pc_redirect_e
  );

  a_stall_flush_d_exclusive: assert property (
    @(posedge clk) !(ctrl.stall_d && ctrl.flush_d)
  );

  // A frozen E must not let the in-flight instruction duplicate into M.
  a_stall_e_flushes_m: assert property (
    @(posedge clk) ctrl.stall_e |-> ctrl.flush_m
  );

endmodule : hazard_control_unit

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_control_unit
//
// Directed-vector bench for hazard_control_unit (MUL_LAT=3, CNT_W=4 so the
// saturation point is reachable quickly). Inputs change 1 time unit after a
// rising edge and outputs are sampled 1 time unit later, mid-cycle.
// Control vectors are compared as {stall_f,stall_d,stall_e,flush_d,flush_e,flush_m}.
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;

  localparam int MUL_LAT = 3;
  localparam int CNT_W   = 4;

  localparam logic [5:0] C_NONE     = 6'b000000;
  localparam logic [5:0] C_RESET    = 6'b000111;
  localparam logic [5:0] C_REDIRECT = 6'b000110;
  localparam logic [5:0] C_MUL      = 6'b111001;
  localparam logic [5:0] C_LOADUSE  = 6'b110010;

  logic clk;
  logic rst_n;

  int tests_run = 0;
  int tests_failed = 0;

  hazard_control_unit_if #(.CNT_W(CNT_W)) bus ();

  hazard_control_unit #(
    .MUL_LAT (MUL_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ctrl_vec();
    return {bus.stall_f, bus.stall_d, bus.stall_e,
            bus.flush_d, bus.flush_e, bus.flush_m};
  endfunction

  // Advance one clock and land 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.reg_read_addr1_d = '0;
    bus.reg_read_addr2_d = '0;
    bus.reg_read_en_d    = '0;
    bus.reg_read_addr1_e = '0;
    bus.reg_read_addr2_e = '0;
    bus.reg_write_addr_e = '0;
    bus.reg_write_en_e   = 1'b0;
    bus.dmem_read_en_e   = 1'b0;
    bus.mul_en_e         = 1'b0;
    bus.pc_redirect_e    = 1'b0;
    bus.reg_write_addr_m = '0;
    bus.reg_write_en_m   = 1'b0;
    bus.reg_write_addr_w = '0;
    bus.reg_write_en_w   = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    bus.dmem_read_en_e   = 1'b1;
    bus.reg_write_en_e   = 1'b1;
    bus.reg_write_addr_e = rd;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    // A forwarding match during reset must still yield 00.
    bus.reg_read_addr1_e = 5'd7;
    bus.reg_write_addr_m = 5'd7;
    bus.reg_write_en_m   = 1'b1;
    bus.mul_en_e         = 1'b1;
    #2;
    check("reset_ctrl", 32'(ctrl_vec()), 32'(C_RESET));
    check("reset_fwd_a", 32'(bus.forward_a_e), 32'd0);
    check("reset_mul_busy", 32'(bus.mul_busy), 32'd0);
    tick();
    tick();
    check("reset_stall_cycles", 32'(bus.stall_cycles), 32'd0);
    check("reset_flush_events", 32'(bus.flush_events), 32'd0);

    rst_n = 1'b1;
    clear_inputs();
    settle();
    check("idle_ctrl", 32'(ctrl_vec()), 32'(C_NONE));

    // ---------------- load-use through rs1 ----------------
    set_load(5'd5);
    bus.reg_read_addr1_d = 5'd5;
    bus.reg_read_en_d    = 2'b01;
    settle();
    check("lu_rs1_stall", 32'(ctrl_vec()), 32'(C_LOADUSE));
    tick();
    clear_inputs();  // bubble now in E
    settle();
    check("lu_rs1_release", 32'(ctrl_vec()), 32'(C_NONE));
    check("lu_rs1_count", 32'(bus.stall_cycles), 32'd1);

    // ---------------- load into x0: no hazard ----------------
    set_load(5'd0);
    bus.reg_read_addr1_d = 5'd0;
    bus.reg_read_en_d    = 2'b01;
    settle();
    check("lu_x0_ctrl", 32'(ctrl_vec()), 32'(C_NONE));
    tick();
    check("lu_x0_count", 32'(bus.stall_cycles), 32'd1);

    // ---------------- load-use through rs2 ----------------
    clear_inputs();
    set_load(5'd9);
    bus.reg_read_addr2_d = 5'd9;
    bus.reg_read_en_d    = 2'b10;
    settle();
    check("lu_rs2_stall", 32'(ctrl_vec()), 32'(C_LOADUSE));
    // Same address match but rs2 marked unused: no hazard.
    bus.reg_read_en_d = 2'b01;
    settle();
    check("lu_rs2_unused", 32'(ctrl_vec()), 32'(C_NONE));
    bus.reg_read_en_d = 2'b10;
    settle();
    tick();
    clear_inputs();
    settle();
    check("lu_rs2_count", 32'(bus.stall_cycles), 32'd2);

    // ---------------- multiply, MUL_LAT=3 ----------------
    bus.mul_en_e = 1'b1;
    settle();
    check("mul_c1_ctrl", 32'(ctrl_vec()), 32'(C_MUL));
    check("mul_c1_busy", 32'(bus.mul_busy), 32'd0);
    tick();
    check("mul_c2_ctrl", 32'(ctrl_vec()), 32'(C_MUL));
    check("mul_c2_busy", 32'(bus.mul_busy), 32'd1);
    tick();
    check("mul_c3_ctrl", 32'(ctrl_vec()), 32'(C_NONE));
    check("mul_c3_busy", 32'(bus.mul_busy), 32'd1);
    tick();
    bus.mul_en_e = 1'b0;  // multiply moved to M
    settle();
    check("mul_c4_ctrl", 32'(ctrl_vec()), 32'(C_NONE));
    check("mul_c4_busy", 32'(bus.mul_busy), 32'd0);
    check("mul_count", 32'(bus.stall_cycles), 32'd4);

    // ---------------- redirect beats load-use and mul ----------------
    set_load(5'd5);
    bus.reg_read_addr1_d = 5'd5;
    bus.reg_read_en_d    = 2'b01;
    bus.mul_en_e         = 1'b1;
    bus.pc_redirect_e    = 1'b1;
    settle();
    check("redir_ctrl", 32'(ctrl_vec()), 32'(C_REDIRECT));
    tick();
    clear_inputs();
    settle();
    check("redir_count", 32'(bus.flush_events), 32'd1);
    check("redir_no_stall_count", 32'(bus.stall_cycles), 32'd4);
    check("redir_no_mul", 32'(bus.mul_busy), 32'd0);

    // ---------------- forwarding ----------------
    bus.reg_read_addr1_e = 5'd7;
    bus.reg_read_addr2_e = 5'd7;
    bus.reg_write_addr_m = 5'd7;
    bus.reg_write_en_m   = 1'b1;
    bus.reg_write_addr_w = 5'd7;
    bus.reg_write_en_w   = 1'b1;
    settle();
    check("fwd_mw_a", 32'(bus.forward_a_e), 32'd2);
    check("fwd_mw_b", 32'(bus.forward_b_e), 32'd2);
    bus.reg_write_en_m = 1'b0;
    settle();
    check("fwd_w_a", 32'(bus.forward_a_e), 32'd1);
    check("fwd_w_b", 32'(bus.forward_b_e), 32'd1);
    bus.reg_write_addr_w = 5'd0;
    settle();
    check("fwd_none_a", 32'(bus.forward_a_e), 32'd0);
    check("fwd_none_b", 32'(bus.forward_b_e), 32'd0);
    // Independent operands: only rs2 matches M.
    bus.reg_read_addr1_e = 5'd4;
    bus.reg_read_addr2_e = 5'd3;
    bus.reg_write_addr_m = 5'd3;
    bus.reg_write_en_m   = 1'b1;
    bus.reg_write_addr_w = 5'd4;
    bus.reg_write_en_w   = 1'b1;
    settle();
    check("fwd_split_a", 32'(bus.forward_a_e), 32'd1);
    check("fwd_split_b", 32'(bus.forward_b_e), 32'd2);
    // x0 destination in M is never forwarded.
    bus.reg_read_addr1_e = 5'd0;
    bus.reg_write_addr_m = 5'd0;
    settle();
    check("fwd_x0_a", 32'(bus.forward_a_e), 32'd0);
    clear_inputs();
    tick();

    // ---------------- reset in the middle of a multiply ----------------
    bus.mul_en_e = 1'b1;
    tick();  // first MUL_WAIT cycle
    tick();  // second MUL_WAIT cycle
    rst_n = 1'b0;
    settle();
    check("rstmul_ctrl", 32'(ctrl_vec()), 32'(C_RESET));
    check("rstmul_busy", 32'(bus.mul_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.mul_en_e = 1'b0;
    settle();
    check("rstmul_after_ctrl", 32'(ctrl_vec()), 32'(C_NONE));
    check("rstmul_after_busy", 32'(bus.mul_busy), 32'd0);
    check("rstmul_after_stalls", 32'(bus.stall_cycles), 32'd0);
    check("rstmul_after_flushes", 32'(bus.flush_events), 32'd0);

    // ---------------- counter saturation at 2^CNT_W-1 ----------------
    set_load(5'd12);
    bus.reg_read_addr2_d = 5'd12;
    bus.reg_read_en_d    = 2'b11;
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall_cycles", 32'(bus.stall_cycles), 32'd15);
    clear_inputs();
    bus.pc_redirect_e = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("sat_flush_events", 32'(bus.flush_events), 32'd15);
    check("sat_stall_hold", 32'(bus.stall_cycles), 32'd15);
    clear_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_hazard_control_unit
